// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync pulses, display window and strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] hpos_d;
  logic [CNT_W-1:0] vpos_d;
  logic             hsync_d;
  logic             vsync_d;
  logic             display_on_d;

  // Sync/display flags are derived from the next counts so they line up with the registered counts.
  always_comb begin
    h_wrap = (hpos >= H_LAST);
    v_wrap = (vpos >= V_LAST);
    hpos_d = h_wrap ? '0 : hpos + ONE;
    vpos_d = vpos;
    if (h_wrap) begin
      vpos_d = v_wrap ? '0 : vpos + ONE;
    end
    hsync_d      = (hpos_d >= HS_FIRST && hpos_d <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d      = (vpos_d >= VS_FIRST && vpos_d <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
    display_on_d = (hpos_d < H_ACT) && (vpos_d < V_ACT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hpos        <= hpos_d;
      vpos        <= vpos_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      display_on  <= display_on_d;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (pix_ce && h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end
`else
  // Counter absent; FRAME_W is still sanity-checked so configurations stay portable.
  if (FRAME_W == 0) begin : g_bad_frame_w
    $error("FRAME_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny 8x6 active-high instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Default-geometry instance
  logic       d_reset, d_ce;
  logic [9:0] d_hpos, d_vpos;
  logic       d_hsync, d_vsync, d_display_on, d_line_start, d_frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] d_frame_cnt;
`endif

  vga_timing_gen u_dut_d (
    .clk         (clk),
    .reset       (d_reset),
    .pix_ce      (d_ce),
    .hpos        (d_hpos),
    .vpos        (d_vpos),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .display_on  (d_display_on),
    .line_start  (d_line_start),
    .frame_start (d_frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (d_frame_cnt)
`endif
  );

  // Small instance: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), active-high syncs
  logic       s_reset, s_ce;
  logic [9:0] s_hpos, s_vpos;
  logic       s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] s_frame_cnt;
`endif

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_dut_s (
    .clk         (clk),
    .reset       (s_reset),
    .pix_ce      (s_ce),
    .hpos        (s_hpos),
    .vpos        (s_vpos),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .display_on  (s_display_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (s_frame_cnt)
`endif
  );

  // Default-instance model state and tallies
  int dm_h = 0, dm_v = 0;
  logic dm_ls = 1'b0, dm_fs = 1'b0;
  int d_bad_pos = 0, d_bad_sync = 0, d_bad_disp = 0, d_bad_strobe = 0;
  int d_hs_low = 0, d_disp_off = 0, d_ls_cnt = 0;

  task automatic d_step(input logic ce);
    logic hs_exp, vs_exp, disp_exp;
    d_ce = ce;
    @(posedge clk);
    #1;
    dm_ls = 1'b0;
    dm_fs = 1'b0;
    if (ce) begin
      if (dm_h == 799) begin
        dm_h  = 0;
        dm_v  = (dm_v == 524) ? 0 : dm_v + 1;
        dm_ls = 1'b1;
        dm_fs = (dm_v == 0);
      end else begin
        dm_h++;
      end
    end
    hs_exp   = !(dm_h >= 656 && dm_h <= 751);
    vs_exp   = !(dm_v >= 490 && dm_v <= 491);
    disp_exp = (dm_h < 640) && (dm_v < 480);
    if (d_hpos !== dm_h[9:0] || d_vpos !== dm_v[9:0]) d_bad_pos++;
    if (d_hsync !== hs_exp || d_vsync !== vs_exp) d_bad_sync++;
    if (d_display_on !== disp_exp) d_bad_disp++;
    if (d_line_start !== dm_ls || d_frame_start !== dm_fs) d_bad_strobe++;
    if (d_hsync === 1'b0) d_hs_low++;
    if (d_display_on === 1'b0) d_disp_off++;
    if (d_line_start === 1'b1) d_ls_cnt++;
  endtask

  // Small-instance model state and tallies
  int sm_h = 0, sm_v = 0;
  logic sm_ls = 1'b0, sm_fs = 1'b0;
  int s_bad_pos = 0, s_bad_sync = 0, s_bad_disp = 0, s_bad_strobe = 0;
  int s_cyc = 0, s_fs_cnt = 0, s_fs_last = 0, s_fs_prev = 0;

  task automatic s_step(input logic ce);
    logic hs_exp, vs_exp, disp_exp;
    s_ce = ce;
    @(posedge clk);
    #1;
    s_cyc++;
    sm_ls = 1'b0;
    sm_fs = 1'b0;
    if (ce) begin
      if (sm_h == 7) begin
        sm_h  = 0;
        sm_v  = (sm_v == 5) ? 0 : sm_v + 1;
        sm_ls = 1'b1;
        sm_fs = (sm_v == 0);
      end else begin
        sm_h++;
      end
    end
    hs_exp   = (sm_h >= 5 && sm_h <= 6);
    vs_exp   = (sm_v == 4);
    disp_exp = (sm_h < 4) && (sm_v < 3);
    if (s_hpos !== sm_h[9:0] || s_vpos !== sm_v[9:0]) s_bad_pos++;
    if (s_hsync !== hs_exp || s_vsync !== vs_exp) s_bad_sync++;
    if (s_display_on !== disp_exp) s_bad_disp++;
    if (s_line_start !== sm_ls || s_frame_start !== sm_fs) s_bad_strobe++;
    if (s_frame_start === 1'b1) begin
      s_fs_prev = s_fs_last;
      s_fs_last = s_cyc;
      s_fs_cnt++;
    end
  endtask

  initial begin
    d_reset = 1'b1;
    s_reset = 1'b1;
    d_ce    = 1'b1;
    s_ce    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hpos",   32'(d_hpos), 32'd0);
    check("rst_vpos",   32'(d_vpos), 32'd0);
    check("rst_disp",   32'(d_display_on), 32'd1);
    check("rst_hsync",  32'(d_hsync), 32'd1);
    check("rst_vsync",  32'(d_vsync), 32'd1);
    check("rst_lstart", 32'(d_line_start), 32'd0);
    check("rst_fstart", 32'(d_frame_start), 32'd0);
    check("rst_s_hsync", 32'(s_hsync), 32'd0);
    check("rst_s_vsync", 32'(s_vsync), 32'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("rst_fcnt", 32'(d_frame_cnt), 32'd0);
`endif

    // One full line at full rate
    d_reset = 1'b0;
    for (int i = 0; i < 800; i++) d_step(1'b1);
    check("line_hs_low",   32'(d_hs_low), 32'd96);
    check("line_disp_off", 32'(d_disp_off), 32'd160);
    check("line_ls_cnt",   32'(d_ls_cnt), 32'd1);
    check("line_end_h",    32'(d_hpos), 32'd0);
    check("line_end_v",    32'(d_vpos), 32'd1);
    check("line_end_ls",   32'(d_line_start), 32'd1);

    // Half-rate line: 1600 clk per line
    for (int i = 0; i < 800; i++) begin
      d_step(1'b0);
      d_step(1'b1);
    end
    check("half_h",  32'(d_hpos), 32'd0);
    check("half_v",  32'(d_vpos), 32'd2);
    check("half_ls", 32'(d_ls_cnt), 32'd2);

    // Strobe drops and counts hold when pix_ce is low
    for (int i = 0; i < 800; i++) d_step(1'b1);
    d_step(1'b0);
    check("hold_ls", 32'(d_line_start), 32'd0);
    check("hold_h",  32'(d_hpos), 32'd0);
    check("hold_v",  32'(d_vpos), 32'd3);

    // Async reset mid-line while hsync asserted and display off
    for (int i = 0; i < 700; i++) d_step(1'b1);
    check("pre_rst_hsync", 32'(d_hsync), 32'd0);
    d_reset = 1'b1;
    #1;
    check("arst_h",     32'(d_hpos), 32'd0);
    check("arst_v",     32'(d_vpos), 32'd0);
    check("arst_hsync", 32'(d_hsync), 32'd1);
    check("arst_disp",  32'(d_display_on), 32'd1);
    @(posedge clk);
    #1;
    d_reset = 1'b0;
    dm_h = 0;
    dm_v = 0;
    d_step(1'b1);
    check("post_rst_h",  32'(d_hpos), 32'd1);
    check("post_rst_v",  32'(d_vpos), 32'd0);
    check("post_rst_ls", 32'(d_line_start), 32'd0);
    check("post_rst_fs", 32'(d_frame_start), 32'd0);
    check("d_model_pos",    32'(d_bad_pos), 32'd0);
    check("d_model_sync",   32'(d_bad_sync), 32'd0);
    check("d_model_disp",   32'(d_bad_disp), 32'd0);
    check("d_model_strobe", 32'(d_bad_strobe), 32'd0);
    d_reset = 1'b1;

    // Small instance: full-rate frame is 48 clk
    s_reset = 1'b0;
    for (int i = 0; i < 48; i++) s_step(1'b1);
    check("s_fs_first", 32'(s_fs_last), 32'd48);
    check("s_fs_cnt1",  32'(s_fs_cnt), 32'd1);
    check("s_frame_ls", 32'(s_line_start), 32'd1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("s_fcnt1", 32'(s_frame_cnt), 32'd1);
`endif

    // Half rate: frame period doubles to 96 clk
    for (int i = 0; i < 96; i++) begin
      s_step(1'b0);
      s_step(1'b1);
    end
    check("s_half_period", 32'(s_fs_last - s_fs_prev), 32'd96);
    check("s_fs_cnt3",     32'(s_fs_cnt), 32'd3);

    // Run to 255 frames, then one more to exercise the silent wrap
    for (int i = 0; i < 252 * 48; i++) s_step(1'b1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("s_fcnt255", 32'(s_frame_cnt), 32'd255);
`endif
    for (int i = 0; i < 48; i++) s_step(1'b1);
    check("s_fs_cnt256", 32'(s_fs_cnt), 32'd256);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("s_fcnt_wrap", 32'(s_frame_cnt), 32'd0);
`endif

    // Reset at (5,4): both active-high syncs asserted
    for (int i = 0; i < 37; i++) s_step(1'b1);
    check("s_pre_hsync", 32'(s_hsync), 32'd1);
    check("s_pre_vsync", 32'(s_vsync), 32'd1);
    s_reset = 1'b1;
    #1;
    check("s_arst_hsync", 32'(s_hsync), 32'd0);
    check("s_arst_vsync", 32'(s_vsync), 32'd0);
    check("s_arst_h",     32'(s_hpos), 32'd0);
    check("s_arst_v",     32'(s_vpos), 32'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("s_arst_fcnt", 32'(s_frame_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    s_reset = 1'b0;
    sm_h = 0;
    sm_v = 0;
    s_step(1'b1);
    check("s_post_rst_h",  32'(s_hpos), 32'd1);
    check("s_post_rst_fs", 32'(s_frame_start), 32'd0);
    check("s_model_pos",    32'(s_bad_pos), 32'd0);
    check("s_model_sync",   32'(s_bad_sync), 32'd0);
    check("s_model_disp",   32'(s_bad_disp), 32'd0);
    check("s_model_strobe", 32'(s_bad_strobe), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
